// File: rtl/async_queue_source_param.sv
// async_queue_source_param: write-clock half of a gray-pointer async FIFO.
// Build option: define ASYNC_QUEUE_SRC_PARITY_EN to add the mem_par port.
//
// Parameters: DATA_W, DEPTH_LOG2, SYNC_STAGES, AFULL_THRESH.
// Ports:
//   clock, reset         write clock, async active-high reset
//   enq_valid/bits/ready enqueue handshake
//   async_ridx           sink read pointer (gray), from sink domain
//   ridx_valid           sink alive indication
//   sink_reset_n         sink-domain reset, active-low
//   async_mem            flat storage array, entry i at [i*DATA_W +: DATA_W]
//   async_widx           write pointer (gray), registered
//   widx_valid           source alive indication
//   source_reset_n       ~reset
//   level, almost_full   conservative occupancy and threshold flag
//   mem_par              per-entry even parity (parity build only)
module async_queue_source_param #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 3,
  parameter int SYNC_STAGES  = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enq_valid,
  input  logic [DATA_W-1:0]                enq_bits,
  output logic                             enq_ready,
  input  logic [DEPTH_LOG2:0]              async_ridx,
  input  logic                             ridx_valid,
  input  logic                             sink_reset_n,
  output logic [(2**DEPTH_LOG2)*DATA_W-1:0] async_mem,
  output logic [DEPTH_LOG2:0]              async_widx,
  output logic                             widx_valid,
  output logic                             source_reset_n,
  output logic [DEPTH_LOG2:0]              level,
  output logic                             almost_full
`ifdef ASYNC_QUEUE_SRC_PARITY_EN
  ,
  output logic [(2**DEPTH_LOG2)-1:0]       mem_par
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  // Gray pointer of a full queue: top two bits inverted vs. read pointer.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (DEPTH_LOG2 - 1);
  localparam logic [PW-1:0] AFULL_L   = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Either side's reset tears down the link handshake.
  logic link_rst;
  assign link_rst = reset | ~sink_reset_n;

  logic [SYNC_STAGES-1:0] src_v0_q;
  logic [SYNC_STAGES-1:0] src_v1_q;
  logic [SYNC_STAGES-1:0] sink_ext_q;
  logic [SYNC_STAGES-1:0] sink_valid_q;
  logic [PW-1:0]          ridx_q [SYNC_STAGES];

  always_ff @(posedge clock or posedge link_rst) begin
    if (link_rst) begin
      src_v0_q   <= '0;
      src_v1_q   <= '0;
      sink_ext_q <= '0;
    end else begin
      src_v0_q   <= {src_v0_q[SYNC_STAGES-2:0], 1'b1};
      src_v1_q   <= {src_v1_q[SYNC_STAGES-2:0],
                     src_v0_q[SYNC_STAGES-1]};
      sink_ext_q <= {sink_ext_q[SYNC_STAGES-2:0], ridx_valid};
    end
  end

  // Kept on the local reset only so that sink_valid drops a few
  // cycles after the sink goes away rather than instantly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sink_valid_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        ridx_q[i] <= '0;
    end else begin
      sink_valid_q <= {sink_valid_q[SYNC_STAGES-2:0],
                       sink_ext_q[SYNC_STAGES-1]};
      ridx_q[0] <= async_ridx;
      for (int i = 1; i < SYNC_STAGES; i++)
        ridx_q[i] <= ridx_q[i-1];
    end
  end

  logic          sink_valid;
  logic [PW-1:0] ridx_sync;
  assign sink_valid = sink_valid_q[SYNC_STAGES-1];
  assign ridx_sync  = ridx_q[SYNC_STAGES-1];

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] widx_q;
  logic          ready_q;
  logic [PW-1:0] level_q;
  logic          afull_q;

  logic          fire;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wgray_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ;
  logic          ready_d;
  logic [PW-1:0] level_d;
  logic          afull_d;

  always_comb begin
    fire    = enq_valid & ready_q & sink_valid;
    wbin_d  = '0;
    if (sink_valid)
      wbin_d = wbin_q + {{(PW-1){1'b0}}, fire};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rbin    = gray2bin(ridx_sync);
    occ     = wbin_d - rbin;
    ready_d = sink_valid & (wgray_d != (ridx_sync ^ FULL_MASK));
    level_d = sink_valid ? occ : '0;
    afull_d = sink_valid & (occ >= AFULL_L);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbin_q  <= '0;
      widx_q  <= '0;
      ready_q <= 1'b0;
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      widx_q  <= wgray_d;
      ready_q <= ready_d;
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  // Slot index derived from the gray pointer, so source and sink
  // agree on placement without a binary conversion on either side.
  logic [DEPTH_LOG2-1:0] slot;
  assign slot = widx_q[DEPTH_LOG2-1:0] ^
                (DEPTH_LOG2'(widx_q[DEPTH_LOG2]) << (DEPTH_LOG2 - 1));

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (fire)
      mem_q[slot] <= enq_bits;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign async_mem[g*DATA_W +: DATA_W] = mem_q[g];
  end

`ifdef ASYNC_QUEUE_SRC_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clock) begin
    if (fire)
      par_q[slot] <= ^enq_bits;
  end

  assign mem_par = par_q;
`endif

  assign enq_ready      = ready_q & sink_valid;
  assign async_widx     = widx_q;
  assign widx_valid     = src_v1_q[SYNC_STAGES-1];
  assign source_reset_n = ~reset;
  assign level          = level_q;
  assign almost_full    = afull_q;

endmodule

// File: tb/tb_async_queue_source_param.sv
// tb_async_queue_source_param: scoreboard bench for the async FIFO source.
// Covers ramp, fill, drain, wrap, sink reset and (optionally) parity.
module tb_async_queue_source_param;

  localparam int DW    = 32;
  localparam int DL    = 3;
  localparam int SS    = 3;
  localparam int AT    = 6;
  localparam int DEPTH = 8;
  localparam int PW    = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  enq_valid = 1'b0;
  logic [DW-1:0]         enq_bits = '0;
  logic                  enq_ready;
  logic [PW-1:0]         async_ridx = '0;
  logic                  ridx_valid = 1'b1;
  logic                  sink_reset_n = 1'b1;
  logic [DEPTH*DW-1:0]   async_mem;
  logic [PW-1:0]         async_widx;
  logic                  widx_valid;
  logic                  source_reset_n;
  logic [PW-1:0]         level;
  logic                  almost_full;
`ifdef ASYNC_QUEUE_SRC_PARITY_EN
  logic [DEPTH-1:0]      mem_par;
`endif

  async_queue_source_param #(
    .DATA_W(DW), .DEPTH_LOG2(DL),
    .SYNC_STAGES(SS), .AFULL_THRESH(AT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enq_valid(enq_valid),
    .enq_bits(enq_bits),
    .enq_ready(enq_ready),
    .async_ridx(async_ridx),
    .ridx_valid(ridx_valid),
    .sink_reset_n(sink_reset_n),
    .async_mem(async_mem),
    .async_widx(async_widx),
    .widx_valid(widx_valid),
    .source_reset_n(source_reset_n),
    .level(level),
    .almost_full(almost_full)
`ifdef ASYNC_QUEUE_SRC_PARITY_EN
    ,
    .mem_par(mem_par)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int slot_of(input logic [PW-1:0] g);
    logic [DL-1:0] s;
    s = g[DL-1:0];
    s[DL-1] = s[DL-1] ^ g[DL];
    return int'(s);
  endfunction

  typedef struct {
    int            s;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sbq[$];
  logic [DW-1:0] exp_mem [DEPTH];
  bit            known   [DEPTH];
  int            wcnt = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    ent_t e;
    e.s = slot_of(gray(wcnt));
    e.d = d;
    sbq.push_back(e);
    wcnt++;
  endtask

  task automatic pop_check();
    ent_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      exp_mem[e.s] = e.d;
      known[e.s]   = 1'b1;
      chk("widx", async_widx, gray(wcnt));
      for (int i = 0; i < DEPTH; i++)
        if (known[i])
          chk($sformatf("mem%0d", i),
              async_mem[i*DW +: DW], exp_mem[i]);
    end
  endtask

  initial begin
    int hist[$];
    int fires;
    bit seen_wrap;
    logic [PW-1:0] prev_g;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // power-on
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", enq_ready, 0);
    chk("rst_wvalid", widx_valid, 0);
    chk("rst_widx", async_widx, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_srcn", source_reset_n, 0);
    reset = 1'b0;
    #1;
    chk("srcn", source_reset_n, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("ramp_wv%0d", k), widx_valid, k >= 6);
      chk($sformatf("ramp_rdy%0d", k), enq_ready, k >= 7);
    end
    chk("ramp_level", level, 0);

    // fill
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1;
      enq_bits  = 32'hA0 + i;
      push(enq_bits);
      step();
      pop_check();
      chk($sformatf("fill_lvl%0d", i), level, i + 1);
      chk($sformatf("fill_af%0d", i), almost_full, i >= 5);
      chk($sformatf("fill_rdy%0d", i), enq_ready, i < 7);
    end
    enq_bits = 32'hDEAD_BEEF;
    repeat (2) begin
      step();
      chk("full_widx", async_widx, 4'hC);
      chk("full_mem0", async_mem[0 +: DW], exp_mem[0]);
    end
    enq_valid = 1'b0;

    // drain one entry
    async_ridx = gray(1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("drn_rdy%0d", k), enq_ready, k == 4);
      chk($sformatf("drn_lvl%0d", k), level, (k == 4) ? 7 : 8);
    end
    enq_valid = 1'b1;
    enq_bits  = 32'hB0;
    push(enq_bits);
    step();
    enq_valid = 1'b0;
    pop_check();
    chk("b0_widx", async_widx, 4'hD);
    chk("b0_lvl", level, 8);
    chk("b0_rdy", enq_ready, 0);

    // wrap with the sink pointer trailing by 5 cycles
    repeat (5) hist.push_back(wcnt);
    fires     = 0;
    seen_wrap = 1'b0;
    prev_g    = async_widx;
    for (int c = 0; c < 400 && fires < 20; c++) begin
      hist.push_back(wcnt);
      async_ridx = gray(hist.pop_front());
      enq_valid  = 1'b1;
      enq_bits   = $urandom;
      if (enq_ready) push(enq_bits);
      step();
      if (sbq.size() != 0) begin
        pop_check();
        fires++;
        if (prev_g == 4'h8 && async_widx == 4'h0)
          seen_wrap = 1'b1;
        prev_g = async_widx;
      end
    end
    enq_valid = 1'b0;
    chk("wrap_fires", fires, 20);
    chk("wrap_seen", seen_wrap, 1);

    // park at level 4, then pull the sink reset
    async_ridx = gray(wcnt - 4);
    repeat (5) step();
    chk("pre_lvl", level, 4);
    chk("pre_rdy", enq_ready, 1);
    chk("pre_af", almost_full, 0);
    sink_reset_n = 1'b0;
    async_ridx   = '0;
    enq_valid    = 1'b1;
    enq_bits     = 32'h5555_AAAA;
    #1;
    chk("srst_wv", widx_valid, 0);
    step();
    step();
    sink_reset_n = 1'b1;
    enq_valid    = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 2) begin
        chk("srst_widx", async_widx, 0);
        chk("srst_lvl", level, 0);
        chk("srst_af", almost_full, 0);
      end
      chk($sformatf("rr_wv%0d", k), widx_valid, k >= 6);
      chk($sformatf("rr_rdy%0d", k), enq_ready, k >= 7);
    end
    chk("rr_lvl", level, 0);
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    sbq.delete();
    wcnt = 0;

    // post-recovery writes; also exercise parity
    enq_valid = 1'b1;
    enq_bits  = 32'h0000_0001;
    push(enq_bits);
    step();
    pop_check();
    enq_bits = 32'h0000_0003;
    push(enq_bits);
    step();
    enq_valid = 1'b0;
    pop_check();
    chk("post_lvl", level, 2);
`ifdef ASYNC_QUEUE_SRC_PARITY_EN
    chk("par0", mem_par[0], 1);
    chk("par1", mem_par[1], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
